// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bundle between the execute stage (master)
// and the data-memory responder (slave).
interface data_sram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ld_type;
    logic [31:0] rdata;
    logic [31:0] ld_data;
    logic        rvalid;
    logic        stallreq;

    modport master (
        output en, wen, addr, wdata, ld_type,
        input  rdata, ld_data, rvalid, stallreq
    );

    modport slave (
        input  en, wen, addr, wdata, ld_type,
        output rdata, ld_data, rvalid, stallreq
    );
endinterface

// File: rtl/data_sram_resp.sv
// Word-organised, byte-writable data memory with WAIT_CYCLES wait states,
// a stall request while busy, and load extraction for the MEM/WB path.
module data_sram_resp #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic             clk,
    input logic             rst,
    data_sram_resp_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state;
    logic [3:0]        cnt;

    logic [3:0]        l_wen;
    logic [ADDR_W-1:0] l_idx;
    logic [1:0]        l_off;
    logic [31:0]       l_wdata;
    logic [2:0]        l_ld_type;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              done;
    logic [3:0]        a_wen;
    logic [ADDR_W-1:0] a_idx;
    logic [1:0]        a_off;
    logic [31:0]       a_wdata;
    logic [2:0]        a_ld_type;
    logic [31:0]       word;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;
    logic [31:0]       ld_next;
    logic              unused_addr;

    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    // With zero wait states the access completes on the accepting edge, so the
    // live request is used; otherwise the latched copy drives the completion.
    always_comb begin
        accept    = (state == S_IDLE) && bus.en && !rst;
        a_wen     = l_wen;
        a_idx     = l_idx;
        a_off     = l_off;
        a_wdata   = l_wdata;
        a_ld_type = l_ld_type;
        if (state == S_IDLE) begin
            a_wen     = bus.wen;
            a_idx     = bus.addr[ADDR_W+1:2];
            a_off     = bus.addr[1:0];
            a_wdata   = bus.wdata;
            a_ld_type = bus.ld_type;
        end
        if (WAIT_CYCLES == 0) done = accept;
        else                  done = (state == S_WAIT) && (cnt == '0) && !rst;
        bus.stallreq = (accept && (WAIT_CYCLES != 0)) ||
                       ((state == S_WAIT) && (cnt != '0));
    end

    always_comb begin
        word  = mem[a_idx];
        sel_b = 8'(word >> {a_off, 3'b000});
        sel_h = a_off[1] ? word[31:16] : word[15:0];
        case (a_ld_type)
            3'b001:  ld_next = {{24{sel_b[7]}}, sel_b};
            3'b010:  ld_next = {24'h000000, sel_b};
            3'b011:  ld_next = {{16{sel_h[15]}}, sel_h};
            3'b100:  ld_next = {16'h0000, sel_h};
            default: ld_next = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus.rdata   <= '0;
            bus.ld_data <= '0;
            bus.rvalid  <= 1'b0;
        end else begin
            bus.rvalid <= 1'b0;
            if (accept) begin
                if (WAIT_CYCLES != 0) begin
                    state <= S_WAIT;
                    cnt   <= 4'(WAIT_CYCLES - 1);
                end
            end else if (state == S_WAIT) begin
                if (cnt == '0) state <= S_IDLE;
                else           cnt   <= cnt - 4'd1;
            end
            if (done && (a_wen == '0)) begin
                bus.rdata   <= word;
                bus.ld_data <= ld_next;
                bus.rvalid  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            l_wen     <= bus.wen;
            l_idx     <= bus.addr[ADDR_W+1:2];
            l_off     <= bus.addr[1:0];
            l_wdata   <= bus.wdata;
            l_ld_type <= bus.ld_type;
        end
    end

    // Storage is deliberately not reset; a reset-dropped access never commits.
    always_ff @(posedge clk) begin
        if (done) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_wen[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: a zero-wait and a three-wait responder driven with directed
// and random traffic, checked against a word-array reference model.
module tb_data_sram_resp;
    logic clk = 1'b0;
    logic rst0, rst3;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] ld;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    logic [31:0] mdl [int];

    data_sram_resp_if b0 ();
    data_sram_resp_if b3 ();

    data_sram_resp #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
    data_sram_resp #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Load result from a stored word, by the load rules rather than by bit slicing
    function automatic logic [31:0] extract(logic [31:0] w, logic [2:0] lt, logic [1:0] off);
        int unsigned b, h;
        b = (w / (32'd1 << (8 * off))) % 256;
        h = (w / (32'd1 << (16 * off[1]))) % 65536;
        case (lt)
            3'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic drive(int k, logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d, logic [2:0] lt);
        if (k == 0) begin
            b0.en = e; b0.wen = w; b0.addr = a; b0.wdata = d; b0.ld_type = lt;
        end else begin
            b3.en = e; b3.wen = w; b3.addr = a; b3.wdata = d; b3.ld_type = lt;
        end
    endtask

    function automatic logic stall(int k);
        return (k == 0) ? b0.stallreq : b3.stallreq;
    endfunction

    // Called at a negedge; returns at the negedge where the next request may start.
    task automatic issue(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d, logic [2:0] lt);
        int          wc;
        int          key;
        logic [31:0] old;
        exp_t        e;
        wc  = (k == 0) ? 0 : 3;
        key = k * 65536 + int'(a[13:2]);
        drive(k, 1'b1, w, a, d, lt);
        #1 chk("stall_accept", 32'(stall(k)), 32'(wc != 0));
        old = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
        if (w == 4'b0000) begin
            e.rd  = old;
            e.ld  = extract(old, lt, a[1:0]);
            e.cyc = cyc + wc + 1;
            if (k == 0) q0.push_back(e);
            else        q3.push_back(e);
        end else begin
            for (int i = 0; i < 4; i++)
                if (w[i]) old[8*i +: 8] = d[8*i +: 8];
            mdl[key] = old;
        end
        @(negedge clk);
        for (int j = 1; j <= wc; j++) begin
            drive(k, 1'($urandom), 4'($urandom), $urandom, $urandom, 3'($urandom));
            #1 chk("stall_wait", 32'(stall(k)), 32'(j < wc));
            @(negedge clk);
        end
        drive(k, 1'b0, 4'b0000, 32'h0, 32'h0, 3'd0);
    endtask

    task automatic directed(int k);
        issue(k, 4'b1111, 32'h10, 32'h11223344, 3'd0);
        issue(k, 4'b0000, 32'h10, 32'h0, 3'd0);
        issue(k, 4'b0100, 32'h12, 32'h00AB0000, 3'd0);
        issue(k, 4'b0000, 32'h10, 32'h0, 3'd0);
        issue(k, 4'b0000, 32'h12, 32'h0, 3'd1);
        issue(k, 4'b0000, 32'h12, 32'h0, 3'd2);
        issue(k, 4'b1111, 32'h20, 32'h80015566, 3'd0);
        issue(k, 4'b0000, 32'h22, 32'h0, 3'd3);
        issue(k, 4'b0000, 32'h22, 32'h0, 3'd4);
        issue(k, 4'b0000, 32'h20, 32'h0, 3'd3);
        issue(k, 4'b0000, 32'h21, 32'h0, 3'd3);
        issue(k, 4'b1111, 32'h4010, 32'hCAFEF00D, 3'd0);
        issue(k, 4'b0000, 32'h0010, 32'h0, 3'd0);
    endtask

    task automatic random_ops(int k, int n);
        for (int i = 0; i < 16; i++)
            issue(k, 4'b1111, 32'(i * 4), $urandom, 3'd0);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFFC03F;
            if ($urandom_range(1, 0) == 1)
                issue(k, 4'b0000, a, $urandom, 3'($urandom_range(7, 0)));
            else
                issue(k, 4'($urandom_range(15, 1)), a, $urandom, 3'd0);
            repeat ($urandom_range(1, 0)) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("stall_w0", 32'(b0.stallreq), 32'd0);
        if (b0.rvalid) begin
            if (q0.size() == 0) chk("unexpected_rvalid0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("rvalid_cycle0", 32'(cyc), 32'(e.cyc));
                chk("rdata0", b0.rdata, e.rd);
                chk("ld_data0", b0.ld_data, e.ld);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b3.rvalid) begin
            if (q3.size() == 0) chk("unexpected_rvalid3", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                chk("rvalid_cycle3", 32'(cyc), 32'(e.cyc));
                chk("rdata3", b3.rdata, e.rd);
                chk("ld_data3", b3.ld_data, e.ld);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b1, 4'b1111, 32'h30, 32'h12345678, 3'd0);
        drive(3, 1'b1, 4'b1111, 32'h30, 32'h12345678, 3'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall3", 32'(b3.stallreq), 32'd0);
        chk("rst_rdata0", b0.rdata, 32'd0);
        chk("rst_ld0", b0.ld_data, 32'd0);
        chk("rst_rvalid0", 32'(b0.rvalid), 32'd0);
        chk("rst_rdata3", b3.rdata, 32'd0);
        chk("rst_ld3", b3.ld_data, 32'd0);
        chk("rst_rvalid3", 32'(b3.rvalid), 32'd0);
        drive(0, 1'b0, 4'b0000, 32'h0, 32'h0, 3'd0);
        drive(3, 1'b0, 4'b0000, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        directed(0);
        directed(3);
        random_ops(0, 80);
        random_ops(3, 60);

        // Reset while a write waits: it must be dropped without a response
        issue(3, 4'b1111, 32'h30, 32'h00000000, 3'd0);
        issue(3, 4'b0000, 32'h34, 32'h0, 3'd0);
        drive(3, 1'b1, 4'b1111, 32'h30, 32'hDEADBEEF, 3'd0);
        #1 chk("stall_sw", 32'(b3.stallreq), 32'd1);
        @(negedge clk);
        drive(3, 1'b0, 4'b0000, 32'h0, 32'h0, 3'd0);
        rst3 = 1'b1;
        #1 chk("stall_in_rst", 32'(b3.stallreq), 32'd1);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("stall_after_rst", 32'(b3.stallreq), 32'd0);
        chk("rdata_after_rst", b3.rdata, 32'd0);
        repeat (4) begin
            @(negedge clk);
            #1 chk("stall_idle", 32'(b3.stallreq), 32'd0);
        end
        issue(3, 4'b0000, 32'h30, 32'h0, 3'd0);

        repeat (8) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
